// File: rtl/sar_result_fifo.sv
// SAR result capture: shadows the comparator handshake and queues each
// finished 8-bit code in a first-word-fall-through FIFO with overflow status.
module sar_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   En,
    input  logic                   Op,
    input  logic                   Om,
    input  logic [7:0]             D,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [CW-1:0]          conv_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [3:0]    r_dec_cnt;
    logic          r_cap_done;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic [CW-1:0] r_conv_count;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr;
    logic w_drop;
    logic w_valid;

    assign w_push  = En && (r_dec_cnt == 4'd8) && !r_cap_done;
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid && out_ready;
    assign w_full  = (r_level == LW'(DEPTH));
    // A pop on the same edge frees the slot the full-FIFO push needs
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec_cnt  <= '0;
            r_cap_done <= 1'b0;
        end else if (!En) begin
            r_dec_cnt  <= '0;
            r_cap_done <= 1'b0;
        end else begin
            if ((Op || Om) && (r_dec_cnt != 4'd8))
                r_dec_cnt <= r_dec_cnt + 4'd1;
            if (w_push)
                r_cap_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= D;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow   <= 1'b0;
            r_conv_count <= '0;
        end else begin
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_ovf)
                r_overflow <= 1'b0;
            if (w_push)
                r_conv_count <= r_conv_count + CW'(1);
        end
    end

    assign out_valid  = w_valid;
    assign out_data   = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign conv_count = r_conv_count;

endmodule

// File: tb/tb_sar_result_fifo.sv
// Bench for sar_result_fifo: vector table, corner sequences and a
// queue-based reference model checked every cycle.
module tb_sar_result_fifo;

    localparam int DEPTH = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] code;
        int         abort_n;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       En = 1'b0, Op = 1'b0, Om = 1'b0;
    logic [7:0] D = 8'h00;
    logic       out_ready = 1'b0, clr_ovf = 1'b0;

    logic [7:0]  out_data, out_data4;
    logic        out_valid, out_valid4;
    logic [2:0]  fifo_level, fifo_level4;
    logic        overflow, overflow4;
    logic [15:0] conv_count;
    logic [3:0]  conv_count4;

    sar_result_fifo #(.DEPTH(DEPTH), .CW(16)) dut (
        .clk(clk), .rst(rst), .En(En), .Op(Op), .Om(Om), .D(D),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf),
        .conv_count(conv_count)
    );

    sar_result_fifo #(.DEPTH(DEPTH), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .En(En), .Op(Op), .Om(Om), .D(D),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .fifo_level(fifo_level4), .overflow(overflow4), .clr_ovf(clr_ovf),
        .conv_count(conv_count4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    int         m_cnt = 0;
    logic       m_ovf = 1'b0;
    logic       exp_push = 1'b0;
    logic [7:0] exp_code = 8'h00;
    bit         md_pop, md_drop;
    bit         mon_en = 1'b0;
    bit         bp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: FIFO as a queue, updated once per clock from stimulus intent
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            md_pop  = (m_q.size() != 0) && out_ready;
            md_drop = 1'b0;
            if (exp_push) begin
                m_cnt++;
                if (m_q.size() < DEPTH || md_pop)
                    m_q.push_back(exp_code);
                else
                    md_drop = 1'b1;
            end
            if (md_pop)
                void'(m_q.pop_front());
            if (md_drop)
                m_ovf = 1'b1;
            else if (clr_ovf)
                m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst) begin
            chk("mon_valid", 32'(out_valid), 32'(m_q.size() != 0));
            chk("mon_level", 32'(fifo_level), 32'(m_q.size()));
            chk("mon_ovf", 32'(overflow), 32'(m_ovf));
            chk("mon_count", 32'(conv_count), 32'(m_cnt[15:0]));
            chk("mon_count4", 32'(conv_count4), 32'(m_cnt[3:0]));
            chk("mon_data", 32'(out_data),
                32'((m_q.size() != 0) ? m_q[0] : 8'h00));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (bp_en)
            out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        tick();
        rst = 1'b0;
        En = 0; Op = 0; Om = 0; D = 0;
        out_ready = 0; clr_ovf = 0; exp_push = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic conv(input logic [7:0] code, input bit lat, input bit rop);
        for (int k = 0; k < 8; k++) begin
            tick();
            En = 1'b1; Op = code[k]; Om = !code[k]; D = code;
        end
        tick();
        if (lat)
            chk("lat_pre", 32'(out_valid), 32'd0);
        Op = 1'b0; Om = 1'b0;
        exp_code = code;
        exp_push = 1'b1;
        if (rop)
            out_ready = 1'b1;
        tick();
        exp_push = 1'b0;
        En = 1'b0;
        if (rop)
            out_ready = 1'b0;
        if (lat)
            chk("lat_post", 32'(out_valid), 32'd1);
    endtask

    task automatic abort_conv(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            En = 1'b1; Op = 1'b1; Om = 1'b0; D = 8'h5A;
        end
        tick();
        En = 1'b0; Op = 1'b0;
    endtask

    task automatic drain(input bq_t exp);
        tick();
        out_ready = 1'b1;
        foreach (exp[i]) begin
            chk("drain_data", 32'(out_data), 32'(exp[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[5];
        bq_t  eq;

        vt[0] = '{8'h4D, 0, 8'h4D};
        vt[1] = '{8'hFF, 5, 8'hFF};
        vt[2] = '{8'h00, 0, 8'h00};
        vt[3] = '{8'hA5, 3, 8'hA5};
        vt[4] = '{8'h80, 7, 8'h80};

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            En = 1'($urandom); Op = 1'($urandom); Om = 1'($urandom);
            D = 8'($urandom); out_ready = 1'($urandom);
            clr_ovf = 1'($urandom);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            chk("rst_level", 32'(fifo_level), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            chk("rst_count", 32'(conv_count), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            do_reset();
            if (vt[i].abort_n != 0)
                abort_conv(vt[i].abort_n);
            conv(vt[i].code, 1'b1, 1'b0);
            chk("tv_data", 32'(out_data), 32'(vt[i].exp_data));
            chk("tv_level", 32'(fifo_level), 32'd1);
            chk("tv_count", 32'(conv_count), 32'd1);
        end

        do_reset();
        for (int c = 1; c <= 5; c++)
            conv(8'(c), 1'b0, 1'b0);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(conv_count), 32'd5);
        eq.delete();
        for (int c = 1; c <= 4; c++)
            eq.push_back(8'(c));
        drain(eq);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        do_reset();
        for (int c = 1; c <= 4; c++)
            conv(8'(c), 1'b0, 1'b0);
        conv(8'hAA, 1'b0, 1'b1);
        chk("fullpop_level", 32'(fifo_level), 32'd4);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        eq.delete();
        eq.push_back(8'h02);
        eq.push_back(8'h03);
        eq.push_back(8'h04);
        eq.push_back(8'hAA);
        drain(eq);

        do_reset();
        bp_en = 1'b1;
        for (int n = 0; n < 20; n++)
            conv(8'($urandom), 1'b0, 1'b0);
        bp_en = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(conv_count), 32'd20);
        out_ready = 1'b0;

        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 17; n++)
            conv(8'($urandom), 1'b0, 1'b0);
        chk("wrap_cw4", 32'(conv_count4), 32'd1);
        chk("wrap_cw16", 32'(conv_count), 32'd17);
        out_ready = 1'b0;
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
